// File: rtl/pipe_pkg.sv
// Shared stage constants: payload widths and control-bit positions.
// Every stage packs and unpacks its control word through these so the fields line up across stages.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 16;

  localparam int CTRL_REGWR    = 0;
  localparam int CTRL_MEMWR    = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_JUMP     = 3;
  localparam int CTRL_COND_LSB = 4;
  localparam int CTRL_COND_W   = 3;
  localparam int CTRL_LDTY_LSB = 7;
  localparam int CTRL_LDTY_W   = 2;
  localparam int CTRL_LDBYTE   = 9;

  function automatic logic [PIPE_CTRL_W-1:0] pack_ctrl(
    input logic                   reg_wr,
    input logic                   mem_wr,
    input logic                   mem_to_reg,
    input logic                   jump,
    input logic [CTRL_COND_W-1:0] condition,
    input logic [CTRL_LDTY_W-1:0] load_type,
    input logic                   load_byte
  );
    logic [PIPE_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_REGWR]    = reg_wr;
    c[CTRL_MEMWR]    = mem_wr;
    c[CTRL_MEMTOREG] = mem_to_reg;
    c[CTRL_JUMP]     = jump;
    c[CTRL_COND_LSB +: CTRL_COND_W] = condition;
    c[CTRL_LDTY_LSB +: CTRL_LDTY_W] = load_type;
    c[CTRL_LDBYTE]   = load_byte;
    return c;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Purpose: one pipeline entry (valid + ctrl + data); ctrl is zeroed whenever the entry is invalidated.
// Latency: load/clear take effect at the falling clock edge.
// Backpressure: none; the parent decides when to load or clear.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear keeps data so a bubble still shows the last payload downstream.
  always_ff @(negedge clk) begin
    if (Reset) begin
      vld  <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      ctrl <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= ld_data;
      ctrl <= ld_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Purpose: inter-stage register with valid/ready, flush, bubbles and an optional 2-entry skid.
// Latency: an accepted entry appears on out_* at the next falling edge; strict FIFO order.
// Backpressure: SKID=1 in_ready = !skid valid (registered); SKID=0 in_ready = !out_valid | out_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_dat, skid_dat, main_ld_dat;
  logic [CTRL_W-1:0] main_ctl, skid_ctl, main_ld_ctl;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic              in_fire, main_free;

  assign main_free = ~main_vld | out_ready;
  assign in_fire   = in_valid & in_ready & ~flush;

  // Skid only fills while main is held, so a valid skid always implies a valid main.
  always_comb begin
    main_ld     = 1'b0;
    main_clr    = flush;
    skid_ld     = 1'b0;
    skid_clr    = flush;
    main_ld_dat = in_data;
    main_ld_ctl = in_ctrl;
    if (!flush) begin
      if (main_free) begin
        if (skid_vld) begin
          main_ld     = 1'b1;
          main_ld_dat = skid_dat;
          main_ld_ctl = skid_ctl;
          skid_clr    = 1'b1;
        end else if (in_fire) begin
          main_ld = 1'b1;
        end else begin
          main_clr = 1'b1;
        end
      end else if (in_fire) begin
        skid_ld = 1'b1;
      end
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .Reset   (Reset),
    .clear   (main_clr),
    .load    (main_ld),
    .ld_data (main_ld_dat),
    .ld_ctrl (main_ld_ctl),
    .vld     (main_vld),
    .data    (main_dat),
    .ctrl    (main_ctl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .Reset   (Reset),
        .clear   (skid_clr),
        .load    (skid_ld),
        .ld_data (in_data),
        .ld_ctrl (in_ctrl),
        .vld     (skid_vld),
        .data    (skid_dat),
        .ctrl    (skid_ctl)
      );
      assign in_ready = ~skid_vld;
    end else begin : g_noskid
      assign skid_vld = 1'b0;
      assign skid_dat = '0;
      assign skid_ctl = '0;
      assign in_ready = main_free;
    end
  endgenerate

  assign out_valid = main_vld;
  assign out_data  = main_dat;
  assign out_ctrl  = main_ctl;
  assign occ       = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: SKID=1 and SKID=0 builds driven with shared stimulus.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        Reset, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occ;

  logic        in_ready0, out_valid0;
  logic [63:0] out_data0;
  logic [15:0] out_ctrl0;
  logic [1:0]  occ0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .SKID(1)) u_dut (
    .clk(clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occ(occ)
  );

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .SKID(0)) u_dut0 (
    .clk(clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occ(occ0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [15:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Commit edge is the falling edge; observe just after the following rising edge.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b1, 64'h55, 16'hFFFF, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl",  out_ctrl,  16'h0);
    chk("rst_out_data",  out_data,  64'h0);
    chk("rst_occ",       occ,       2'd0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_in_ready0", in_ready0, 1'b1);
    Reset = 1'b0;
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    cyc();
    chk("idle_in_ready", in_ready, 1'b1);

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 16'(i * 3), 1'b1, 1'b0);
      cyc();
      chk("strm_valid", out_valid, 1'b1);
      chk("strm_data",  out_data,  64'(i));
      chk("strm_ctrl",  out_ctrl,  16'(i * 3));
      chk("strm_occ",   occ,       2'd1);
      chk("strm_data0", out_data0, 64'(i));
    end
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    cyc();
    chk("strm_drain_valid", out_valid, 1'b0);
    chk("strm_drain_occ",   occ,       2'd0);

    // Stall with A, B, C offered.
    drive(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0);
    cyc();
    chk("stall_a_data", out_data, 64'hA);
    chk("stall_a_occ",  occ,      2'd1);
    chk("stall_a_rdy",  in_ready, 1'b1);
    drive(1'b1, 64'hB, 16'h00B1, 1'b0, 1'b0);
    cyc();
    chk("stall_b_data", out_data, 64'hA);
    chk("stall_b_occ",  occ,      2'd2);
    chk("stall_b_rdy",  in_ready, 1'b0);
    drive(1'b1, 64'hC, 16'h00C1, 1'b0, 1'b0);
    cyc();
    chk("stall_c_data", out_data, 64'hA);
    chk("stall_c_ctrl", out_ctrl, 16'h00A1);
    chk("stall_c_occ",  occ,      2'd2);
    drive(1'b1, 64'hC, 16'h00C1, 1'b1, 1'b0);
    cyc();
    chk("rel_b_data", out_data, 64'hB);
    chk("rel_b_ctrl", out_ctrl, 16'h00B1);
    chk("rel_b_occ",  occ,      2'd1);
    chk("rel_b_rdy",  in_ready, 1'b1);
    drive(1'b1, 64'hC, 16'h00C1, 1'b1, 1'b0);
    cyc();
    chk("rel_c_data",  out_data,  64'hC);
    chk("rel_c_valid", out_valid, 1'b1);
    chk("rel_c_occ",   occ,       2'd1);
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    cyc();
    chk("rel_done_valid", out_valid, 1'b0);
    chk("rel_done_occ",   occ,       2'd0);

    // Flush while two entries are held; D offered in the flush cycle must vanish.
    drive(1'b1, 64'hE, 16'h00E1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 64'hF, 16'h00F1, 1'b0, 1'b0);
    cyc();
    chk("fl_pre_occ", occ, 2'd2);
    drive(1'b1, 64'hD, 16'h00D1, 1'b1, 1'b1);
    cyc();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ctrl",  out_ctrl,  16'h0);
    chk("fl_occ",   occ,       2'd0);
    chk("fl_rdy",   in_ready,  1'b1);
    chk("fl_no_d",  out_data == 64'hD, 1'b0);
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    cyc();
    chk("fl_after_valid", out_valid, 1'b0);
    chk("fl_after_no_d",  out_data == 64'hD, 1'b0);

    // Bubble between X and Y.
    drive(1'b1, 64'h1111, 16'hFFFF, 1'b1, 1'b0);
    cyc();
    chk("bub_x_ctrl", out_ctrl, 16'hFFFF);
    chk("bub_x_data", out_data, 64'h1111);
    drive(1'b0, 64'hDEAD, 16'h1234, 1'b1, 1'b0);
    cyc();
    chk("bub_gap_ctrl",  out_ctrl,  16'h0);
    chk("bub_gap_valid", out_valid, 1'b0);
    chk("bub_gap_data",  out_data,  64'h1111);
    drive(1'b1, 64'h2222, 16'hFFFF, 1'b1, 1'b0);
    cyc();
    chk("bub_y_ctrl", out_ctrl, 16'hFFFF);
    chk("bub_y_data", out_data, 64'h2222);

    // SKID=0: combinational in_ready follows out_ready within the cycle.
    Reset = 1'b1;
    drive(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
    cyc();
    Reset = 1'b0;
    chk("s0_rst_occ", occ0, 2'd0);
    drive(1'b1, 64'h10, 16'h0010, 1'b0, 1'b0);
    cyc();
    chk("s0_held_data", out_data0, 64'h10);
    chk("s0_held_occ",  occ0,      2'd1);
    drive(1'b1, 64'h20, 16'h0020, 1'b0, 1'b0);
    #1;
    chk("s0_stall_rdy", in_ready0, 1'b0);
    chk("s1_no_comb_rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("s0_go_rdy", in_ready0, 1'b1);
    cyc();
    chk("s0_swap_data",  out_data0,  64'h20);
    chk("s0_swap_ctrl",  out_ctrl0,  16'h0020);
    chk("s0_swap_valid", out_valid0, 1'b1);
    chk("s0_swap_occ",   occ0,       2'd1);
    drive(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
    cyc();
    chk("s0_drain_valid", out_valid0, 1'b0);
    chk("s0_drain_ctrl",  out_ctrl0,  16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
